// File: rtl/exu_bp_perf_ctr.sv
// Branch-resolution performance counter bank: NUM_CTR event-selectable counters
// with wrap/saturate overflow, an atomic snapshot bank and a registered debug port.
module exu_bp_perf_ctr #(
    parameter int NUM_CTR = 6,
    parameter int CTR_W   = 32,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             valid_ff,
    input  logic             predict_t,
    input  logic             predict_nt,
    input  logic             jal,
    input  logic             flush_upper,
    input  logic             cond_mispredict,
    input  logic             target_mispredict,
    input  logic             flush,
    input  logic             freeze,
    input  logic             clr_all,
    input  logic             snap,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CTR_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [1:0]       rd_sel,
    input  logic [AW-1:0]    rd_addr,
    output logic [CTR_W-1:0] rd_data,
    output logic             rd_valid
);

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

    // ctl layout: [4] enable, [3] sat_mode, [2:0] event select
    logic [CTR_W-1:0] cnt_q  [NUM_CTR];
    logic [CTR_W-1:0] snap_q [NUM_CTR];
    logic [4:0]       ctl_q  [NUM_CTR];
    logic [NUM_CTR-1:0] ovf_q;

    logic             qual;
    logic             br;
    logic [7:0]       evt;
    logic [NUM_CTR-1:0] inc;
    logic [NUM_CTR-1:0] wr_val_hit;
    logic [NUM_CTR-1:0] wr_ctl_hit;
    logic [CTR_W-1:0] rd_next;

    always_comb begin
        qual   = valid_ff & ~flush & ~freeze;
        br     = predict_t | predict_nt;
        evt[0] = qual & br;
        evt[1] = qual & predict_t;
        evt[2] = qual & predict_nt;
        evt[3] = qual & br & flush_upper;
        evt[4] = qual & br & cond_mispredict;
        evt[5] = qual & target_mispredict;
        evt[6] = qual & br & ~flush_upper;
        evt[7] = qual & jal;
    end

    // Out-of-range addresses never match any index, so such writes fall away.
    always_comb begin
        inc        = '0;
        wr_val_hit = '0;
        wr_ctl_hit = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            inc[i]        = ctl_q[i][4] & evt[ctl_q[i][2:0]];
            wr_val_hit[i] = wr_en & wr_sel & (wr_addr == AW'(i));
            wr_ctl_hit[i] = wr_en & ~wr_sel & (wr_addr == AW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ovf_q <= '0;
            for (int i = 0; i < NUM_CTR; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
                ctl_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CTR; i++) begin
                if (clr_all) begin
                    cnt_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (wr_val_hit[i]) begin
                    cnt_q[i] <= wr_data;
                    ovf_q[i] <= 1'b0;
                end else if (inc[i]) begin
                    if (cnt_q[i] == CTR_MAX) begin
                        ovf_q[i] <= 1'b1;
                        if (!ctl_q[i][3]) cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CTR_ONE;
                    end
                end
                // Snapshot takes the start-of-cycle value, even against clr_all.
                if (snap) snap_q[i] <= cnt_q[i];
                else if (clr_all) snap_q[i] <= '0;
                if (wr_ctl_hit[i]) ctl_q[i] <= wr_data[4:0];
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (rd_addr == AW'(i)) begin
                case (rd_sel)
                    2'd0:    rd_next = cnt_q[i];
                    2'd1:    rd_next = snap_q[i];
                    2'd2:    rd_next = CTR_W'({ovf_q[i], ctl_q[i]});
                    default: rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_next;
        end
    end

endmodule
